rr_mux_arbiter: RTL

- Round-robin arbiter that shares one parameterised N:1 bus multiplexer among WIDTH requesters.
- Drives the multiplexer select and a one-hot grant, and holds the grant for a multi-beat transaction until the owner's last beat is accepted downstream.
- Sits between requesting units (e.g. fetch and load/store ports) and a shared memory/bus port. The data path itself stays in the external multiplexer.
- A watchdog revokes a grant whose owner stalls.

---
 rtl/rr_mux_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/rr_mux_arbiter.sv
// Round-robin owner selection for a shared N:1 bus mux; one-cycle req-to-gnt latency.
// Grant is held across multi-beat transactions until last is accepted; a stalled owner is revoked by a watchdog.
module rr_mux_arbiter #(
    parameter int WIDTH    = 4,
    parameter int TIMEOUT  = 16,
    localparam int SELW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] req,
    input  logic [WIDTH-1:0] last,
    input  logic             out_ready,
    output logic [WIDTH-1:0] gnt,
    output logic [SELW-1:0]  sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] ack,
    output logic             timeout_err
);

    localparam int CNTW = $clog2(TIMEOUT + 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] gnt_q, gnt_d;
    logic [SELW-1:0]  sel_q, sel_d;
    logic [SELW-1:0]  ptr_q, ptr_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             terr_q, terr_d;

    logic             owner_req;
    logic             beat_acc;
    logic [WIDTH-1:0] others;
    logic [SELW-1:0]  win_idle;
    logic [SELW-1:0]  win_regrant;

    // First set bit of r strictly after p, wrapping around to p itself last.
    function automatic logic [SELW-1:0] rr_pick(input logic [WIDTH-1:0] r,
                                                input logic [SELW-1:0]  p);
        logic [SELW-1:0] w;
        logic [SELW-1:0] idx_s;
        logic            found;
        int              idx;
        w     = '0;
        found = 1'b0;
        for (int k = 1; k <= WIDTH; k++) begin
            idx   = (int'(p) + k) % WIDTH;
            idx_s = SELW'(idx);
            if (!found && r[idx_s]) begin
                w     = idx_s;
                found = 1'b1;
            end
        end
        return w;
    endfunction

    assign owner_req   = req[sel_q];
    assign out_valid   = (state_q == S_GRANT) && owner_req;
    assign beat_acc    = out_valid && out_ready;
    assign others      = req & ~gnt_q;
    assign win_idle    = rr_pick(req, ptr_q);
    assign win_regrant = rr_pick(others, sel_q);

    assign gnt         = gnt_q;
    assign sel         = sel_q;
    assign timeout_err = terr_q;
    assign ack         = reset ? '0 : (gnt_q & {WIDTH{beat_acc}});

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        terr_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (|req) begin
                    state_d         = S_GRANT;
                    gnt_d           = '0;
                    gnt_d[win_idle] = 1'b1;
                    sel_d           = win_idle;
                    ptr_d           = win_idle;
                end
            end
            S_GRANT: begin
                if (beat_acc && last[sel_q]) begin
                    cnt_d = '0;
                    // Releasing owner is masked out so others get a turn without a bubble.
                    if (|others) begin
                        gnt_d              = '0;
                        gnt_d[win_regrant] = 1'b1;
                        sel_d              = win_regrant;
                        ptr_d              = win_regrant;
                    end else begin
                        state_d = S_IDLE;
                        gnt_d   = '0;
                    end
                end else if (owner_req) begin
                    cnt_d = '0;
                end else if (cnt_q == CNTW'(TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    cnt_d   = '0;
                    terr_d  = 1'b1;
                end else if (cnt_q != CNTW'(TIMEOUT)) begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= SELW'(WIDTH - 1);
            cnt_q   <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
        end
    end

endmodule
